// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / MRET sequencer.
// Define TRAP_CTRL_VECTORED_EN for vectored interrupt targets.
module trap_ctrl #(
  parameter int unsigned RESET_BUSY_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        is_ecall_i,
  input  logic        is_ebreak_i,
  input  logic        is_mret_i,
  input  logic        illegal_i,
  input  logic        irq_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        pc_force_o,
  output logic [31:0] pc_force_addr_o,
  output logic        flush_o
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_EPC,
    SAVE_CAUSE,
    SAVE_STATUS,
    REDIRECT,
    RESTORE_STATUS,
    REDIRECT_MRET
  } state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  state_t      state_q;
  logic [31:0] cause_q;
  logic [31:0] status_q;
  logic [31:0] rst_cnt_q;

  logic        ready;
  logic        ev_irq;
  logic        ev_ill;
  logic        ev_ebrk;
  logic        ev_ecall;
  logic        ev_mret;
  logic        ev_trap;
  logic        ev_any;
  logic [31:0] ev_cause;
  logic [31:0] trap_status;
  logic [31:0] mret_status;
  logic [31:0] base;
  logic [31:0] trap_target;
  logic        unused_bits;

  assign ready = !rst_i
    && (state_q == IDLE)
    && (rst_cnt_q == '0);

  // Priority masks keep the event set one-hot.
  assign ev_irq = ready & irq_i
    & csr_mstatus_i[3];
  assign ev_ill = ready & valid_i
    & illegal_i & ~ev_irq;
  assign ev_ebrk = ready & valid_i
    & is_ebreak_i & ~illegal_i
    & ~ev_irq;
  assign ev_ecall = ready & valid_i
    & is_ecall_i & ~is_ebreak_i
    & ~illegal_i & ~ev_irq;
  assign ev_mret = ready & valid_i
    & is_mret_i & ~is_ecall_i
    & ~is_ebreak_i & ~illegal_i
    & ~ev_irq;

  assign ev_trap = ev_irq | ev_ill
    | ev_ebrk | ev_ecall;
  assign ev_any = ev_trap | ev_mret;

  always_comb begin
    ev_cause = '0;
    unique case (1'b1)
      ev_irq:   ev_cause = 32'h8000_000B;
      ev_ill:   ev_cause = 32'h0000_0002;
      ev_ebrk:  ev_cause = 32'h0000_0003;
      ev_ecall: ev_cause = 32'h0000_000B;
      default:  ev_cause = '0;
    endcase
  end

  always_comb begin
    trap_status = status_q;
    trap_status[7] = status_q[3];
    trap_status[3] = 1'b0;
    trap_status[12:11] = 2'b11;
  end

  always_comb begin
    mret_status = csr_mstatus_i;
    mret_status[3] = csr_mstatus_i[7];
    mret_status[7] = 1'b1;
    mret_status[12:11] = 2'b11;
  end

  assign base = {csr_mtvec_i[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  assign trap_target =
    (cause_q[31] && csr_mtvec_i[1:0] == 2'b01)
    ? base + {cause_q[29:0], 2'b00}
    : base;
  assign unused_bits =
    ^{pc_i[1:0], csr_mepc_i[1:0]};
`else
  assign trap_target = base;
  assign unused_bits = ^{pc_i[1:0],
    csr_mepc_i[1:0], csr_mtvec_i[1:0]};
`endif

  always_comb begin
    pc_force_addr_o = '0;
    case (state_q)
      REDIRECT:
        pc_force_addr_o = trap_target;
      REDIRECT_MRET:
        pc_force_addr_o =
          {csr_mepc_i[31:2], 2'b00};
      default:
        pc_force_addr_o = '0;
    endcase
  end

  assign busy_o = !rst_i
    && (state_q != IDLE || rst_cnt_q != '0);
  assign stall_o = busy_o | ev_any;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cause_q     <= '0;
      status_q    <= '0;
      rst_cnt_q   <= RESET_BUSY_CYCLES;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      pc_force_o  <= 1'b0;
      flush_o     <= 1'b0;
    end else begin
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      pc_force_o  <= 1'b0;
      flush_o     <= 1'b0;
      if (rst_cnt_q != '0)
        rst_cnt_q <= rst_cnt_q - 32'd1;
      case (state_q)
        IDLE: begin
          if (ev_trap) begin
            cause_q     <= ev_cause;
            status_q    <= csr_mstatus_i;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= A_MEPC;
            csr_wdata_o <= {pc_i[31:2], 2'b00};
            state_q     <= SAVE_EPC;
          end else if (ev_mret) begin
            status_q    <= csr_mstatus_i;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= A_MSTATUS;
            csr_wdata_o <= mret_status;
            state_q     <= RESTORE_STATUS;
          end
        end
        SAVE_EPC: begin
          csr_we_o    <= 1'b1;
          csr_waddr_o <= A_MCAUSE;
          csr_wdata_o <= cause_q;
          state_q     <= SAVE_CAUSE;
        end
        SAVE_CAUSE: begin
          csr_we_o    <= 1'b1;
          csr_waddr_o <= A_MSTATUS;
          csr_wdata_o <= trap_status;
          state_q     <= SAVE_STATUS;
        end
        SAVE_STATUS: begin
          pc_force_o <= 1'b1;
          flush_o    <= 1'b1;
          state_q    <= REDIRECT;
        end
        RESTORE_STATUS: begin
          pc_force_o <= 1'b1;
          flush_o    <= 1'b1;
          state_q    <= REDIRECT_MRET;
        end
        REDIRECT:      state_q <= IDLE;
        REDIRECT_MRET: state_q <= IDLE;
        default:       state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl.
// Directed and random trap/MRET traffic vs. a behavioural model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i, is_ecall_i, is_ebreak_i;
  logic        is_mret_i, illegal_i, irq_i;
  logic [31:0] pc_i, csr_mstatus_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i;
  logic        busy_o, stall_o, csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        pc_force_o, flush_o;
  logic [31:0] pc_force_addr_o;

  trap_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .valid_i(valid_i),
    .is_ecall_i(is_ecall_i),
    .is_ebreak_i(is_ebreak_i),
    .is_mret_i(is_mret_i),
    .illegal_i(illegal_i),
    .irq_i(irq_i), .pc_i(pc_i),
    .csr_mstatus_i(csr_mstatus_i),
    .csr_mtvec_i(csr_mtvec_i),
    .csr_mepc_i(csr_mepc_i),
    .busy_o(busy_o), .stall_o(stall_o),
    .csr_we_o(csr_we_o),
    .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o),
    .pc_force_o(pc_force_o),
    .pc_force_addr_o(pc_force_addr_o),
    .flush_o(flush_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          redir;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_we = 0;
  int n_force = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per visible DUT action.
  initial forever begin
    @(negedge clk);
    if (!rst_i) begin
      if (csr_we_o) n_we++;
      if (pc_force_o) n_force++;
      if (csr_we_o || pc_force_o) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected: we=%0b force=%0b addr %h data %h",
                   csr_we_o, pc_force_o, csr_waddr_o, csr_wdata_o);
        end else begin
          mon_e = q.pop_front();
          chk("kind", 32'(pc_force_o), 32'(mon_e.redir));
          if (mon_e.redir)
            chk("target", pc_force_addr_o, mon_e.data);
          else begin
            chk("waddr", 32'(csr_waddr_o), 32'(mon_e.addr));
            chk("wdata", csr_wdata_o, mon_e.data);
          end
          chk("cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      chk("flush", 32'(flush_o), 32'(pc_force_o));
      if (!csr_we_o)
        chk("idle_w", csr_wdata_o | 32'(csr_waddr_o), 32'd0);
      if (!pc_force_o)
        chk("idle_pc", pc_force_addr_o, 32'd0);
    end
  end

  // Event taken: 0 none, 1 irq, 2 illegal, 3 ebreak, 4 ecall, 5 mret.
  function automatic int pick(input logic v, ec, eb, mr, il, ir,
                              input logic [31:0] ms);
    if (ir && ms[3]) return 1;
    if (!v) return 0;
    if (il) return 2;
    if (eb) return 3;
    if (ec) return 4;
    if (mr) return 5;
    return 0;
  endfunction

  task automatic expect_seq(input int ev,
                            input logic [31:0] pc, ms, tv, ep,
                            input int n);
    logic [31:0] cause, tgt, st;
    if (ev == 5) begin
      st = (ms & ~32'h1888) | 32'h1880 | (((ms >> 7) & 32'd1) << 3);
      q.push_back('{1'b0, 12'h300, st, n + 1});
      q.push_back('{1'b1, 12'h000, ep & ~32'h3, n + 2});
    end else if (ev != 0) begin
      cause = (ev == 1) ? 32'h8000000B :
              (ev == 2) ? 32'h2 :
              (ev == 3) ? 32'h3 : 32'hB;
      st = (ms & ~32'h1888) | 32'h1800 | (((ms >> 3) & 32'd1) << 7);
      tgt = tv & ~32'h3;
`ifdef TRAP_CTRL_VECTORED_EN
      if (ev == 1 && (tv & 32'h3) == 32'h1)
        tgt = tgt + ((cause & 32'h7FFFFFFF) << 2);
`endif
      q.push_back('{1'b0, 12'h341, pc & ~32'h3, n + 1});
      q.push_back('{1'b0, 12'h342, cause, n + 2});
      q.push_back('{1'b0, 12'h300, st, n + 3});
      q.push_back('{1'b1, 12'h000, tgt, n + 4});
    end
  endtask

  task automatic clear_in();
    valid_i = 1'b0; is_ecall_i = 1'b0;
    is_ebreak_i = 1'b0; is_mret_i = 1'b0;
    illegal_i = 1'b0; irq_i = 1'b0;
  endtask

  task automatic garbage();
    valid_i = 1'($urandom_range(0, 1));
    is_ecall_i = 1'($urandom_range(0, 1));
    is_ebreak_i = 1'($urandom_range(0, 1));
    is_mret_i = 1'($urandom_range(0, 1));
    illegal_i = 1'($urandom_range(0, 1));
    irq_i = 1'($urandom_range(0, 1));
    pc_i = $urandom;
    csr_mstatus_i = $urandom;
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic issue(input logic v, ec, eb, mr, il, ir,
                       input logic [31:0] pc, ms, tv, ep,
                       input bit hold);
    int ev, busy_n;
    valid_i = v; is_ecall_i = ec; is_ebreak_i = eb;
    is_mret_i = mr; illegal_i = il; irq_i = ir;
    pc_i = pc; csr_mstatus_i = ms;
    csr_mtvec_i = tv; csr_mepc_i = ep;
    ev = pick(v, ec, eb, mr, il, ir, ms);
    expect_seq(ev, pc, ms, tv, ep, cyc);
    #1;
    chk("stall", 32'(stall_o), 32'(ev != 0));
    @(posedge clk); #1;
    busy_n = 0;
    while (busy_o && busy_n < 10) begin
      chk("stall_busy", 32'(stall_o), 32'd1);
      busy_n++;
      if (hold) begin
        clear_in();
        valid_i = 1'b1;
        is_ecall_i = 1'b1;
      end else begin
        garbage();
      end
      @(posedge clk); #1;
    end
    chk("busy_cycles", 32'(busy_n),
        32'((ev == 0) ? 0 : (ev == 5) ? 2 : 4));
    clear_in();
  endtask

  initial begin
    int w0, f0;
    clear_in();
    pc_i = '0; csr_mstatus_i = '0;
    csr_mtvec_i = '0; csr_mepc_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_we", 32'(csr_we_o), 32'd0);
    chk("rst_force", 32'(pc_force_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    issue(1, 1, 0, 0, 0, 0, 32'h104, 32'h8, 32'h200, 32'h0, 0);
    issue(1, 0, 0, 1, 0, 0, 32'h50, 32'h1880, 32'h200, 32'h108, 0);
    issue(1, 1, 0, 0, 0, 1, 32'h300, 32'h8, 32'h200, 32'h0, 0);
    issue(1, 1, 0, 0, 0, 1, 32'h304, 32'h0, 32'h200, 32'h0, 0);

    w0 = n_we; f0 = n_force;
    issue(1, 1, 0, 0, 0, 0, 32'h400, 32'h8, 32'h200, 32'h0, 1);
    chk("hold_writes", 32'(n_we - w0), 32'd3);
    chk("hold_force", 32'(n_force - f0), 32'd1);

    issue(0, 0, 0, 0, 0, 1, 32'h500, 32'h8, 32'h201, 32'h0, 0);
    issue(1, 1, 1, 1, 1, 0, 32'h600, 32'h0, 32'h200, 32'h0, 0);

    // Reset landing in the middle of a trap sequence.
    valid_i = 1'b1; is_ecall_i = 1'b1;
    pc_i = 32'h700; csr_mstatus_i = 32'h8;
    csr_mtvec_i = 32'h200;
    expect_seq(4, 32'h700, 32'h8, 32'h200, 32'h0, cyc);
    @(posedge clk); #1;
    clear_in();
    @(posedge clk); #1;
    chk("at_cause", 32'(csr_waddr_o), 32'h342);
    #1;
    rst_i = 1'b1;
    q.delete();
    w0 = n_we; f0 = n_force;
    #1;
    chk("arst_we", 32'(csr_we_o), 32'd0);
    chk("arst_wdata", csr_wdata_o, 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("arst_no_we", 32'(n_we - w0), 32'd0);
    chk("arst_no_force", 32'(n_force - f0), 32'd0);

    for (int i = 0; i < 300; i++) begin
      issue($urandom_range(0, 9) < 8,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0,
            $urandom, $urandom,
            $urandom, $urandom, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
